// File: rtl/uart_sipo_rx.sv
// Oversampling UART receiver: start/8 data/optional parity/stop, LSB first.
// Recovers each bit at mid-bit, checks parity and stop, strobes done_flag for one cycle.
module uart_sipo_rx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [1:0]    par_mode_q;
    logic          par_bit_q;
    logic          stop_bit_q;
    logic          stop_seen_q;
    logic          seen_high_q;

    logic          tick_last;
    logic          ones_odd;
    logic          perr_d;

    assign rx_s      = sync2_q;
    assign tick_last = (tick_q == FULL_M1);

    always_comb begin
        ones_odd = (^shift_q) ^ par_bit_q;
        perr_d   = 1'b0;
        case (par_mode_q)
            2'b01:   perr_d = ~ones_odd;
            2'b10:   perr_d = ones_odd;
            default: perr_d = 1'b0;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_mode_q   <= '0;
            par_bit_q    <= 1'b0;
            stop_bit_q   <= 1'b0;
            stop_seen_q  <= 1'b0;
            seen_high_q  <= 1'b1;
            data_out     <= '0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            sync1_q   <= data_rx;
            sync2_q   <= sync1_q;
            done_flag <= 1'b0;

            case (state_q)
                IDLE: begin
                    active_flag <= 1'b0;
                    if (rx_s) begin
                        seen_high_q <= 1'b1;
                    end else if (seen_high_q) begin
                        state_q    <= START;
                        tick_q     <= '0;
                        par_mode_q <= parity_type;
                    end
                end

                START: begin
                    active_flag <= 1'b1;
                    if (tick_q == HALF_M1) begin
                        tick_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end else begin
                            // false start: abandon quietly, result outputs untouched
                            state_q     <= IDLE;
                            active_flag <= 1'b0;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                DATA: begin
                    active_flag <= 1'b1;
                    if (tick_last) begin
                        tick_q  <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= (par_mode_q == 2'b01 || par_mode_q == 2'b10) ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                PARITY: begin
                    active_flag <= 1'b1;
                    if (tick_last) begin
                        tick_q    <= '0;
                        par_bit_q <= rx_s;
                        state_q   <= STOP;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                STOP: begin
                    if (!stop_seen_q) begin
                        active_flag <= 1'b1;
                        if (tick_last) begin
                            tick_q      <= '0;
                            stop_bit_q  <= rx_s;
                            stop_seen_q <= 1'b1;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end else begin
                        // a low stop bit blocks restart until the line is seen high
                        data_out     <= shift_q;
                        stop_error   <= ~stop_bit_q;
                        parity_error <= perr_d;
                        done_flag    <= 1'b1;
                        active_flag  <= 1'b0;
                        seen_high_q  <= stop_bit_q;
                        stop_seen_q  <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// Directed bench for uart_sipo_rx: table of frames plus hand-written corner sequences.
module tb_uart_sipo_rx;

    localparam int unsigned OS = 16;

    logic       baud_clk;
    logic       reset;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       parity_error;
    logic       stop_error;
    logic       active_flag;
    logic       done_flag;

    uart_sipo_rx #(.OVERSAMPLE(OS)) dut (
        .baud_clk     (baud_clk),
        .reset        (reset),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    int unsigned cyc = 0;
    always @(posedge baud_clk) cyc++;

    int unsigned done_cnt = 0;
    int unsigned last_done_cyc = 0;
    int unsigned act_rise = 0;
    int unsigned act_fall = 0;
    logic        prev_act = 1'b0;
    logic [7:0]  done_data[$];

    always @(negedge baud_clk) begin
        if (done_flag === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            done_data.push_back(data_out);
        end
        if (active_flag === 1'b1 && prev_act === 1'b0) act_rise = cyc;
        if (active_flag === 1'b0 && prev_act === 1'b1) act_fall = cyc;
        prev_act = active_flag;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        data_rx = b;
        repeat (OS) @(posedge baud_clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        data_rx = 1'b1;
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input logic pb, input logic sb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic check_frame(input string tag, input int unsigned base, input int unsigned t0,
                               input logic [7:0] d, input logic perr, input logic serr,
                               input int unsigned lat);
        check({tag, "_done_count"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_latency"}, 32'(last_done_cyc - t0), 32'(lat));
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_parity_err"}, 32'(parity_error), 32'(perr));
        check({tag, "_stop_err"}, 32'(stop_error), 32'(serr));
        check({tag, "_active_idle"}, 32'(active_flag), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  pt;
        bit          pen;
        logic        pb;
        logic        sb;
        logic        perr;
        logic        serr;
        int unsigned lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned t0;
        int unsigned base;
        logic [7:0]  held;

        // latency counts from the edge after which the start bit is driven:
        // two synchronizer edges, then E, then done at E+153 (E+169 with parity)
        vecs[0] = '{8'hA5, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 156};
        vecs[1] = '{8'h3C, 2'b01, 1, 1'b1, 1'b1, 1'b0, 1'b0, 172};
        vecs[2] = '{8'h3C, 2'b01, 1, 1'b0, 1'b1, 1'b1, 1'b0, 172};
        vecs[3] = '{8'h01, 2'b10, 1, 1'b1, 1'b1, 1'b0, 1'b0, 172};
        vecs[4] = '{8'h01, 2'b10, 1, 1'b0, 1'b1, 1'b1, 1'b0, 172};
        vecs[5] = '{8'h00, 2'b11, 0, 1'b0, 1'b1, 1'b0, 1'b0, 156};
        vecs[6] = '{8'h7E, 2'b01, 1, 1'b1, 1'b1, 1'b0, 1'b0, 172};
        vecs[7] = '{8'h96, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 156};

        reset       = 1'b0;
        data_rx     = 1'b1;
        parity_type = 2'b00;
        repeat (3) @(posedge baud_clk);
        #1;
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_serr", 32'(stop_error), 32'd0);
        check("rst_active", 32'(active_flag), 32'd0);
        check("rst_done", 32'(done_flag), 32'd0);
        reset = 1'b1;
        idle(32);

        for (int i = 0; i < 8; i++) begin
            parity_type = vecs[i].pt;
            base = done_cnt;
            t0   = cyc;
            send_frame(vecs[i].d, vecs[i].pen, vecs[i].pb, vecs[i].sb);
            idle(2 * OS);
            check_frame($sformatf("v%0d", i), base, t0, vecs[i].d, vecs[i].perr, vecs[i].serr, vecs[i].lat);
            if (i == 0) begin
                check("v0_active_rise", 32'(act_rise - t0), 32'd4);
                check("v0_active_fall", 32'(act_fall - t0), 32'd156);
            end
        end

        // parity_type dropped to none mid-frame: still even parity, still 11 bits
        parity_type = 2'b10;
        base = done_cnt;
        t0   = cyc;
        fork
            send_frame(8'h01, 1, 1'b0, 1'b1);
            begin
                repeat (50) @(posedge baud_clk);
                #1;
                parity_type = 2'b00;
            end
        join
        idle(2 * OS);
        check_frame("ptype_switch", base, t0, 8'h01, 1'b1, 1'b0, 172);

        // false start: short low pulse must leave everything untouched
        parity_type = 2'b00;
        held = data_out;
        base = done_cnt;
        data_rx = 1'b0;
        repeat (5) @(posedge baud_clk);
        #1;
        idle(3 * OS);
        check("false_start_done", 32'(done_cnt - base), 32'd0);
        check("false_start_data", 32'(data_out), 32'(held));
        check("false_start_active", 32'(active_flag), 32'd0);
        base = done_cnt;
        t0   = cyc;
        send_frame(8'h5A, 0, 1'b0, 1'b1);
        idle(2 * OS);
        check_frame("after_false", base, t0, 8'h5A, 1'b0, 1'b0, 156);

        // break: low stop bit then 40 bit times low gives exactly one done
        base = done_cnt;
        t0   = cyc;
        send_frame(8'hFF, 0, 1'b0, 1'b0);
        data_rx = 1'b0;
        repeat (40 * OS) @(posedge baud_clk);
        #1;
        check_frame("break", base, t0, 8'hFF, 1'b0, 1'b1, 156);
        idle(2 * OS);
        check("break_no_retrigger", 32'(done_cnt - base), 32'd1);
        base = done_cnt;
        t0   = cyc;
        send_frame(8'hC3, 0, 1'b0, 1'b1);
        idle(2 * OS);
        check_frame("after_break", base, t0, 8'hC3, 1'b0, 1'b0, 156);

        // reset pulse during data bit 4; remaining bits are all ones so nothing restarts
        base = done_cnt;
        fork
            send_frame(8'hF0, 0, 1'b0, 1'b1);
            begin
                repeat (5 * OS + OS / 2) @(posedge baud_clk);
                #1;
                reset = 1'b0;
                @(posedge baud_clk);
                #1;
                reset = 1'b1;
                check("midrst_data", 32'(data_out), 32'd0);
                check("midrst_serr", 32'(stop_error), 32'd0);
                check("midrst_active", 32'(active_flag), 32'd0);
                check("midrst_done", 32'(done_flag), 32'd0);
            end
        join
        idle(3 * OS);
        check("midrst_no_done", 32'(done_cnt - base), 32'd0);

        // back-to-back frames with no idle gap
        base = done_cnt;
        t0   = cyc;
        send_frame(8'h11, 0, 1'b0, 1'b1);
        send_frame(8'h22, 0, 1'b0, 1'b1);
        idle(2 * OS);
        check("b2b_done_count", 32'(done_cnt - base), 32'd2);
        if (done_cnt - base == 2) begin
            check("b2b_first", 32'(done_data[base]), 32'h11);
            check("b2b_second", 32'(done_data[base + 1]), 32'h22);
        end
        check("b2b_latency", 32'(last_done_cyc - t0), 32'd316);
        check("b2b_data", 32'(data_out), 32'h22);
        check("b2b_perr", 32'(parity_error), 32'd0);
        check("b2b_serr", 32'(stop_error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_sipo_rx.md
Name: uart_sipo_rx

Overview:
- Receive-side partner of the UART transmit serializer.
- Consumes the serial line produced by the transmitter, using a start/data/optional-parity/stop frame: LSB first, 1 start bit, 8 data bits, 0 or 1 parity bit, 1 stop bit.
- Oversamples the line, recovers each bit at mid-bit, deserializes to a byte, and checks parity and stop bit.
- Feeds the byte to the core-side receive path through a one-cycle done strobe.

Parameters:
- OVERSAMPLE, 16, baud_clk cycles per bit. Even, at least 4.

Ports:
- baud_clk  input  1  sampling clock, OVERSAMPLE x bit rate.
- reset  input  1  synchronous, active-low. reset==0 at a baud_clk rising edge resets the block.
- data_rx  input  1  asynchronous serial line, idle high.
- parity_type  input  2  00/11 no parity, 01 odd, 10 even.
- data_out  output  8  last received byte.
- parity_error  output  1  parity mismatch on last frame.
- stop_error  output  1  stop bit sampled 0 on last frame.
- active_flag  output  1  high while a frame is being received.
- done_flag  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, data_out=8'h00, parity_error=0, stop_error=0, active_flag=0, done_flag=0.
  - Synchronizer flops=1, counters=0, line_seen_high=1.
  - Reset mid-frame discards the partial frame, with no done_flag pulse.
- Input sync: data_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- States: IDLE, START, DATA, PARITY, STOP. Sample counter tick_cnt (log2(OVERSAMPLE) bits), bit counter bit_cnt (0..7).
- IDLE:
  - active_flag=0.
  - If rx_s==1, set line_seen_high=1.
  - If rx_s==0 and line_seen_high==1: go START, tick_cnt=0, latch parity_type into par_mode. Call this cycle E.
- START:
  - active_flag=1.
  - At tick_cnt==OVERSAMPLE/2-1, check rx_s:
    - rx_s==0: go DATA, tick_cnt=0, bit_cnt=0.
    - rx_s==1 (glitch/false start): go IDLE with no outputs changed.
- DATA:
  - Each time tick_cnt reaches OVERSAMPLE-1, sample rx_s and shift it into shift_reg MSB (right shift, LSB first on the line), then set tick_cnt=0.
  - Data bit k is sampled at cycle E + OVERSAMPLE/2 + (k+1)*OVERSAMPLE.
  - After bit 7: go PARITY if par_mode is 01 or 10, else go STOP.
- PARITY: sample one bit after OVERSAMPLE cycles into par_bit, then go STOP.
- STOP:
  - Sample after OVERSAMPLE cycles. This is mid stop bit: E + OVERSAMPLE/2 + 9*OVERSAMPLE, plus OVERSAMPLE if parity is enabled.
  - On the following edge (sample+1):
    - data_out=shift_reg.
    - stop_error = ~sampled bit.
    - parity_error per the parity rule below.
    - done_flag=1 for exactly one cycle.
    - active_flag=0, state=IDLE.
- Parity rule, with ones = popcount(data)+par_bit:
  - odd (01): error when ones is even.
  - even (10): error when ones is odd.
  - none: parity_error=0.
- Error and data outputs hold until the next completed frame. A false start does not change them.
- Framing error (stop sampled 0): frame still completes with done_flag, stop_error=1, line_seen_high=0. No new start is accepted until rx_s has been 1 for at least one cycle, so a break does not retrigger reception.
- Back-to-back frames: return to IDLE at mid stop bit, so the next start edge arriving a half-bit later is detected normally.
- parity_type changes mid-frame are ignored (par_mode latched at E).
- tick_cnt wraps to 0 at each sample point, never at OVERSAMPLE.

Test Plan:
- No parity, OVERSAMPLE=16, send 0xA5 with stop=1 → data_out=8'hA5, done_flag single pulse at E+153, parity_error=0, stop_error=0, active_flag high E+1..E+152.
- parity_type=01, send 0x3C with parity bit 1 → parity_error=0. Repeat with parity bit 0 → parity_error=1, data_out=8'h3C, done at E+169.
- parity_type=10, send 0x01 with parity 1 → parity_error=0. Switch parity_type to 00 mid-frame → frame still checked as even, still 11 bits.
- False start: data_rx low for 5 cycles then high → returns to IDLE, no done_flag, data_out unchanged. A following valid 0x5A frame receives correctly.
- Framing/break: send 0xFF with stop=0, then hold the line low for 40 bit times → one done_flag, stop_error=1, data_out=8'hFF, no further done_flag until the line goes high and a new start arrives.
- Reset mid-frame: assert reset=0 for 1 cycle during data bit 4 → all outputs 0, state IDLE, no done_flag. Back-to-back frames 0x11 and 0x22 with no idle gap → two done_flag pulses, data_out 8'h11 then 8'h22, no errors.
